ifetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register. It consumes the current `pc`, issues one instruction-memory request at a time, and buffers the returned word into an IF/ID output register with a valid/ready handshake to decode.
- It also produces `pc_next`, which feeds back into the PC register. Stall, advance and branch redirect are therefore all decided here.

---
 rtl/ifetch_unit.sv | 93 +++++++++
 tb/tb_ifetch_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch with IF/ID output register and PC feedback
module ifetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_fault,
  input  logic        id_ready
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t      state_q, state_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_fault_q, id_fault_d;
  logic        misaligned;
  assign misaligned     = |pc[1:0];
  assign imem_req_addr  = pc;
  assign imem_req_valid = state_q == S_REQ && !rst && !redirect_valid && !misaligned;
  assign pc_next        = rst ? pc :
                          redirect_valid ? redirect_pc :
                          (imem_req_valid && imem_req_ready) ? pc + 32'd4 : pc;
  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_instr       = id_instr_q;
  assign id_fault       = id_fault_q;
  always_comb begin
    state_d    = state_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_fault_d = id_fault_q;
    case (state_q)
      S_REQ:
        if (!redirect_valid && misaligned) begin
          id_valid_d = 1'b1;
          id_pc_d    = pc;
          id_instr_d = NOP_INSTR;
          id_fault_d = 1'b1;
          state_d    = S_HOLD;
        end else if (!redirect_valid && imem_req_ready) begin
          state_d = S_WAIT;
        end
      S_WAIT:
        if (redirect_valid) begin
          // a response landing with the redirect already retires the request
          state_d = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          id_valid_d = 1'b1;
          id_pc_d    = pc - 32'd4;
          id_instr_d = imem_rsp_data;
          id_fault_d = 1'b0;
          state_d    = S_HOLD;
        end
      S_HOLD:
        if (redirect_valid || (id_ready && !id_fault_q)) begin
          id_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      S_DROP:
        state_d = imem_rsp_valid ? S_REQ : S_DROP;
      default:
        state_d = S_REQ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_fault_q <= id_fault_d;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: cycle vector table for handshake/PC outputs plus a scoreboard of IF/ID entries
module tb_ifetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] pc_next;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_fault;
  logic        id_ready = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  typedef struct {
    logic        rst, rv;
    logic [31:0] rpc;
    logic        rdy, rsp;
    logic [31:0] rdat;
    logic        idr, e_rv;
    logic [31:0] e_pn;
    logic        e_idv, push;
    logic [31:0] s_pc, s_ins;
    logic        s_flt;
  } vec_t;
  typedef struct {
    logic [31:0] pc, ins;
    logic        flt;
  } ent_t;
  vec_t tbl[$];
  ent_t sb[$];
  ifetch_unit #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_fault(id_fault), .id_ready(id_ready)
  );
  always #5 clk = ~clk;
  // PC register fed back from pc_next
  always @(posedge clk) pc <= rst ? 32'd0 : pc_next;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  function automatic vec_t v(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                             input logic rsp, input logic [31:0] rdat, input logic idr, input logic e_rv,
                             input logic [31:0] e_pn, input logic e_idv, input logic push,
                             input logic [31:0] s_pc, input logic [31:0] s_ins, input logic s_flt);
    vec_t t;
    t.rst = r; t.rv = rv; t.rpc = rpc; t.rdy = rdy; t.rsp = rsp; t.rdat = rdat; t.idr = idr;
    t.e_rv = e_rv; t.e_pn = e_pn; t.e_idv = e_idv; t.push = push;
    t.s_pc = s_pc; t.s_ins = s_ins; t.s_flt = s_flt;
    return t;
  endfunction
  task automatic step(input vec_t r);
    @(negedge clk);
    rst = r.rst; redirect_valid = r.rv; redirect_pc = r.rpc; imem_req_ready = r.rdy;
    imem_rsp_valid = r.rsp; imem_rsp_data = r.rdat; id_ready = r.idr;
    #1;
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, r.e_rv});
    chk("pc_next", pc_next, r.e_pn);
    chk("req_addr", imem_req_addr, pc);
    chk("id_valid", {31'd0, id_valid}, {31'd0, r.e_idv});
    if (r.e_idv) begin
      if (sb.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
      else begin
        chk("id_pc", id_pc, sb[0].pc);
        chk("id_instr", id_instr, sb[0].ins);
        chk("id_fault", {31'd0, id_fault}, {31'd0, sb[0].flt});
        if (r.rv || (r.idr && !sb[0].flt)) void'(sb.pop_front());
      end
    end
    if (r.push) sb.push_back('{pc: r.s_pc, ins: r.s_ins, flt: r.s_flt});
  endtask
  initial begin
    // r  rv rpc           rdy rsp rdat          idr e_rv e_pn          idv push s_pc          s_ins         flt
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 1, 32'h4,        0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 1, 32'hA0,       1, 0, 32'h4,        0, 1, 32'h0,        32'hA0,       0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 0, 32'h4,        1, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 1, 32'h8,        0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 1, 32'hA1,       1, 0, 32'h8,        0, 1, 32'h4,        32'hA1,       0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 0, 32'h8,        1, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 1, 32'hC,        0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 1, 32'hA2,       1, 0, 32'hC,        0, 1, 32'h8,        32'hA2,       0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 0, 32'hC,        1, 0, 0,            0,            0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0, 0, 0,          0, 0, 0,            1, 1, 32'hC,        0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 1, 32'h10,       0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 1, 32'hB3,       0, 0, 32'h10,       0, 1, 32'hC,        32'hB3,       0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0, 0, 0,          1, 0, 0,            0, 0, 32'h10,       1, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 0, 32'h10,       1, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 1, 32'h14,       0, 0, 0,            0,            0));
    tbl.push_back(v(0, 1, 32'h100,      1, 0, 0,            1, 0, 32'h100,      0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 0, 32'h100,      0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 1, 32'hDEAD,     1, 0, 32'h100,      0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 1, 32'h104,      0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 1, 32'h1234,     1, 0, 32'h104,      0, 1, 32'h100,      32'h1234,     0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 0, 32'h104,      1, 0, 0,            0,            0));
    tbl.push_back(v(0, 1, 32'h102,      1, 0, 0,            1, 0, 32'h102,      0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 0, 32'h102,      0, 1, 32'h102,      NOP,          1));
    for (int i = 0; i < 2; i++)
      tbl.push_back(v(0, 0, 0,          1, 0, 0,            1, 0, 32'h102,      1, 0, 0,            0,            0));
    tbl.push_back(v(0, 1, 32'h200,      1, 0, 0,            1, 0, 32'h200,      1, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 1, 32'h204,      0, 0, 0,            0,            0));
    tbl.push_back(v(0, 1, 32'h300,      1, 1, 32'hBAD,      1, 0, 32'h300,      0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 1, 32'h304,      0, 0, 0,            0,            0));
    tbl.push_back(v(1, 0, 0,            1, 1, 32'hEEE,      1, 0, 32'h304,      0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            0, 1, 32'hFFF,      1, 1, 32'h0,        0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 1, 32'h4,        0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 1, 32'hC0,       1, 0, 32'h4,        0, 1, 32'h0,        32'hC0,       0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 0, 32'h4,        1, 0, 0,            0,            0));
    tbl.push_back(v(0, 1, 32'hFFFFFFFC, 1, 0, 0,            1, 0, 32'hFFFFFFFC, 0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 1, 32'h0,        0, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 1, 32'hF0,       1, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 32'hF0,       0));
    tbl.push_back(v(0, 1, 32'h40,       1, 0, 0,            1, 0, 32'h40,       1, 0, 0,            0,            0));
    tbl.push_back(v(0, 0, 0,            1, 0, 0,            1, 1, 32'h44,       0, 0, 0,            0,            0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_fault", {31'd0, id_fault}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_pc_next", pc_next, 32'd0);
    foreach (tbl[i]) step(tbl[i]);
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
